// File: rtl/cn_link_host_pkg.sv
// cn_link_host_pkg: link symbol values and controller state encoding shared by the
// cn_link_host sources.
`default_nettype none

package cn_link_host_pkg;

  // Link symbols: bit8=0 carries a data byte, bit8=1 carries a control code.
  localparam logic [8:0] SYM_IDLE     = 9'h100;
  localparam logic [8:0] SYM_START    = 9'h101;
  localparam logic [8:0] SYM_INIT     = 9'h102;
  localparam logic [8:0] SYM_FINISHED = 9'h103;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_GAP      = 4'd2,
    ST_START    = 4'd3,
    ST_WAIT_FIN = 4'd4,
    ST_INIT     = 4'd5,
    ST_XTX      = 4'd6,
    ST_XRX      = 4'd7,
    ST_OUT      = 4'd8,
    ST_FIN      = 4'd9
  } state_e;

  function automatic logic [8:0] data_sym(input logic [7:0] b);
    return {1'b0, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cn_link_host_rx_shift.sv
// link_rx_shift: classifies incoming link symbols and collects returned data bytes
// into a 128-bit word with a byte count that saturates at 16.
`default_nettype none

module link_rx_shift
  import cn_link_host_pkg::*;
(
  input  logic         clk,
  input  logic         reset_l,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [8:0]   i_sym,
  output logic [127:0] o_data,
  output logic [4:0]   o_cnt,
  output logic         o_is_finished,
  output logic         o_is_bad
);

  logic [127:0] r_data;
  logic [4:0]   r_cnt;
  logic         w_is_data;

  assign w_is_data     = ~i_sym[8];
  assign o_is_finished = (i_sym == SYM_FINISHED);
  assign o_is_bad      = i_sym[8] && (i_sym != SYM_IDLE) && (i_sym != SYM_START) &&
                         (i_sym != SYM_INIT) && (i_sym != SYM_FINISHED);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && w_is_data) begin
      r_data <= {r_data[119:0], i_sym[7:0]};
      if (r_cnt != 5'd16) begin
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  assign o_data = r_data;
  assign o_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: rtl/cn_link_host.sv
// cn_link_host: host-side cn_core link driver; streams the initial state out as data
// symbols, triggers the hash, then reads the result back one 16-byte exchange per word.
`default_nettype none

module cn_link_host
  import cn_link_host_pkg::*;
#(
  parameter int WORDS      = 13,
  parameter int TIMEOUT_W  = 24,
  parameter int RX_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         go,
  input  logic [127:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [8:0]   link_tx,
  input  logic [8:0]   link_rx,
  output logic         busy,
  output logic         done,
  output logic         err_timeout,
  output logic         err_symbol
);

  localparam int WIDX_W = $clog2(WORDS + 1);
  localparam int RXTO_W = $clog2(RX_TIMEOUT + 1);
  localparam logic [WIDX_W-1:0]    WIDX_LAST = WIDX_W'(WORDS - 1);
  localparam logic [RXTO_W-1:0]    RXTO_LAST = RXTO_W'(RX_TIMEOUT - 1);
  // One below all-ones: the increment that would saturate the counter raises the error.
  localparam logic [TIMEOUT_W-1:0] TO_LAST   = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_e                r_state;
  logic [127:0]          r_tx_sh;
  logic [3:0]            r_bcnt;
  logic [WIDX_W-1:0]     r_widx;
  logic                  r_gap;
  logic [TIMEOUT_W-1:0]  r_tcnt;
  logic [RXTO_W-1:0]     r_rxto;
  logic [8:0]            r_link_tx;
  logic                  r_in_ready;
  logic [127:0]          r_out_data;
  logic                  r_out_valid;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err_timeout;
  logic                  r_err_symbol;

  logic                  w_rx_en;
  logic                  w_rx_clr;
  logic [127:0]          w_rx_data;
  logic [4:0]            w_rx_cnt;
  logic                  w_rx_fin;
  logic                  w_rx_bad;

  assign w_rx_en  = (r_state == ST_INIT) || (r_state == ST_XTX) || (r_state == ST_XRX);
  // OUT always precedes a new exchange, so clearing there leaves XTX with an empty count.
  assign w_rx_clr = (r_state == ST_INIT) || (r_state == ST_OUT);

  link_rx_shift u_rx (
    .clk           (clk),
    .reset_l       (reset_l),
    .i_en          (w_rx_en),
    .i_clr         (w_rx_clr),
    .i_sym         (link_rx),
    .o_data        (w_rx_data),
    .o_cnt         (w_rx_cnt),
    .o_is_finished (w_rx_fin),
    .o_is_bad      (w_rx_bad)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state       <= ST_IDLE;
      r_tx_sh       <= '0;
      r_bcnt        <= '0;
      r_widx        <= '0;
      r_gap         <= 1'b0;
      r_tcnt        <= '0;
      r_rxto        <= '0;
      r_link_tx     <= SYM_IDLE;
      r_in_ready    <= 1'b0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_symbol  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_rx_bad) begin
        r_err_symbol <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_link_tx <= SYM_IDLE;
          if (go) begin
            r_state       <= ST_LOAD;
            r_busy        <= 1'b1;
            r_err_timeout <= 1'b0;
            r_err_symbol  <= 1'b0;
            r_in_ready    <= 1'b1;
            r_bcnt        <= '0;
            r_widx        <= '0;
          end
        end
        ST_LOAD: begin
          if (r_bcnt == 4'd0) begin
            if (in_valid && r_in_ready) begin
              r_link_tx  <= data_sym(in_data[127:120]);
              r_tx_sh    <= {in_data[119:0], 8'h00};
              r_bcnt     <= 4'd1;
              r_in_ready <= 1'b0;
            end else begin
              r_link_tx  <= SYM_IDLE;
              r_in_ready <= 1'b1;
            end
          end else begin
            r_link_tx <= data_sym(r_tx_sh[127:120]);
            r_tx_sh   <= {r_tx_sh[119:0], 8'h00};
            r_bcnt    <= r_bcnt + 4'd1;
            if (r_bcnt == 4'd15) begin
              if (r_widx == WIDX_LAST) begin
                r_state <= ST_GAP;
                r_gap   <= 1'b0;
              end else begin
                r_widx     <= r_widx + WIDX_W'(1);
                r_in_ready <= 1'b1;
              end
            end
          end
        end
        ST_GAP: begin
          r_link_tx <= SYM_IDLE;
          r_gap     <= 1'b1;
          if (r_gap) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_link_tx <= SYM_START;
          r_tcnt    <= '0;
          r_state   <= ST_WAIT_FIN;
        end
        ST_WAIT_FIN: begin
          r_link_tx <= SYM_IDLE;
          if (w_rx_fin) begin
            r_state <= ST_INIT;
          end else if (r_tcnt == TO_LAST) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_FIN;
          end else begin
            r_tcnt <= r_tcnt + TIMEOUT_W'(1);
          end
        end
        ST_INIT: begin
          r_link_tx <= SYM_INIT;
          r_widx    <= '0;
          r_bcnt    <= '0;
          r_state   <= ST_XTX;
        end
        ST_XTX: begin
          r_link_tx <= data_sym(8'h00);
          r_bcnt    <= r_bcnt + 4'd1;
          if (r_bcnt == 4'd15) begin
            r_rxto  <= '0;
            r_state <= ST_XRX;
          end
        end
        ST_XRX: begin
          r_link_tx <= SYM_IDLE;
          if (w_rx_cnt == 5'd16) begin
            r_out_data  <= w_rx_data;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end else if (r_rxto == RXTO_LAST) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_FIN;
          end else begin
            r_rxto <= r_rxto + RXTO_W'(1);
          end
        end
        ST_OUT: begin
          r_link_tx <= SYM_IDLE;
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_widx == WIDX_LAST) begin
              r_state <= ST_FIN;
            end else begin
              r_widx  <= r_widx + WIDX_W'(1);
              r_bcnt  <= '0;
              r_state <= ST_XTX;
            end
          end
        end
        ST_FIN: begin
          r_link_tx  <= SYM_IDLE;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_link_tx <= SYM_IDLE;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign link_tx     = r_link_tx;
  assign in_ready    = r_in_ready;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_timeout = r_err_timeout;
  assign err_symbol  = r_err_symbol;

endmodule

`default_nettype wire
